enemy_attack_controller: RTL and testbench
==========================================

// Module: enemy_attack_controller
// PURPOSE
//  Sequences the enemy (CPU) turn on the 5x5 battleship grid. Samples LFSR coordinates from
//  the attack random generator, rejects cells already shot, falls back to a linear scan,
//  issues one shot per turn to the player board with a valid/ack handshake, and reports
//  turn completion. Sits between the game FSM (turn_start/turn_done) and the player board.
// PARAMETERS
//  GRID_N     5   grid side; cells indexed idx = i*GRID_N + j, 0..GRID_N*GRID_N-1
//  MAX_RETRY  8   rejected random samples per turn before switching to linear scan
// PORTS
//  clk          in   1  system clock, all state on posedge
//  rst          in   1  asynchronous reset, active-low
//  new_game     in   1  sync clear of shot history/count; priority over everything but rst
//  turn_start   in   1  1-cycle pulse: begin enemy turn; ignored unless state==IDLE
//  rand_i       in   3  row from random generator, stable at posedge
//  rand_j       in   3  col from random generator, stable at posedge
//  attack_valid out  1  shot request; held high until attack_ack
//  attack_i     out  3  shot row, stable while attack_valid
//  attack_j     out  3  shot col, stable while attack_valid
//  attack_ack   in   1  board accepted shot; sampled only while attack_valid
//  attack_hit   in   1  shot result, valid in same cycle as attack_ack
//  turn_done    out  1  1-cycle pulse: turn finished
//  last_hit     out  1  result of most recent shot, held until next ack
//  board_full   out  1  all GRID_N^2 cells shot (combinational from history)
//  shots_fired  out  5  shots accepted since new_game/reset, saturates at GRID_N^2
// BEHAVIOUR
//  Reset (rst=0): state IDLE, history 0, attack_valid/turn_done/last_hit 0, attack_i/j 0, shots_fired 0.
//  States: IDLE -> SAMPLE -> CHECK -> {SAMPLE | SCAN | FIRE}; SCAN -> FIRE; FIRE -> DONE -> IDLE.
//  IDLE: turn_start & !board_full -> SAMPLE, retry cnt=0; turn_start & board_full -> DONE (no shot).
//  SAMPLE: register rand_i/rand_j into cand.
//  CHECK: cand out of range (>=GRID_N) or already shot = reject; retry cnt+1; cnt==MAX_RETRY -> SCAN
//    else -> SAMPLE. Accept -> FIRE with attack_i/j=cand.
//  SCAN: one cell/cycle from idx 0 upward; first unshot cell -> FIRE. Cannot fail (board_full excluded).
//  FIRE: attack_valid=1. On attack_ack: set history[idx], shots_fired+1, last_hit<=attack_hit,
//    attack_valid 0 next cycle, -> DONE.
//  DONE: turn_done=1 for exactly one cycle, -> IDLE.
//  Latency best case: turn_start edge N -> attack_valid high from edge N+3; ack at M -> turn_done at M+1.
//  new_game in any state: -> IDLE, attack_valid dropped, history/shots_fired/last_hit cleared;
//    same-cycle turn_start ignored. attack_ack outside FIRE ignored.
// CONFIGURATION
//  HUNT_EN defined: after a hit, next turn first tries neighbours of the last hit in order
//    up(i-1), down(i+1), left(j-1), right(j+1), one per cycle in state HUNT, skipping off-grid/shot;
//    first valid -> FIRE; none -> SAMPLE. Hunt origin cleared on miss-only exhaustion or new_game.
//  HUNT_EN undefined: no HUNT state; every turn starts at SAMPLE.
// STRUCTURE
//  battleship_pkg: GRID_N, NCELLS, coord_t (logic [2:0]), atk_state_e enum, function
//    cell_idx(i,j). Sub-module shot_history: NCELLS-bit register, set/clear/lookup/full ports.
// TESTING
//  1 rst low mid-FIRE -> attack_valid=0, shots_fired=0, state IDLE immediately (async).
//  2 empty board, rand=(2,3), turn_start -> attack_valid at +3 edges, attack=(2,3); ack hit=1 ->
//    turn_done next cycle, last_hit=1, shots_fired=1.
//  3 (2,3) already shot, rand=(2,3) then (4,0) -> one reject, attack=(4,0).
//  4 cells 0..6 shot, rand stuck at (0,0) -> after 8 rejects SCAN, attack=(1,2) (idx 7).
//  5 all 25 shot, turn_start -> no attack_valid, turn_done pulse; board_full=1.
//  6 new_game during FIRE with ack -> ack ignored, history 0, state IDLE, no turn_done.
//  7 (HUNT_EN) hit at (0,0) -> next turn attack=(1,0) (up off-grid skipped).

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared grid geometry, coordinate types and attack FSM states for the enemy turn logic.
package battleship_pkg;

  localparam int GRID_N    = 5;
  localparam int NCELLS    = GRID_N * GRID_N;
  localparam int MAX_RETRY = 8;

  typedef logic [2:0] coord_t;
  typedef logic [4:0] idx_t;

  localparam coord_t     GRID_LAST  = coord_t'(GRID_N - 1);
  localparam idx_t       NCELLS_CNT = idx_t'(NCELLS);
  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CHECK,
    SCAN,
    FIRE,
    DONE,
    HUNT
  } atk_state_e;

  // Row-major cell index; only meaningful for in-range coordinates.
  function automatic idx_t cell_idx(input coord_t i, input coord_t j);
    return idx_t'(idx_t'(i) * idx_t'(GRID_N) + idx_t'(j));
  endfunction

endpackage

// File: rtl/enemy_attack_controller_if.sv
// Shot request channel between the enemy attack controller (master) and the player board (slave).
interface enemy_attack_controller_if import battleship_pkg::*; ();

  logic   attack_valid;
  coord_t attack_i;
  coord_t attack_j;
  logic   attack_ack;
  logic   attack_hit;

  modport master (
    output attack_valid, attack_i, attack_j,
    input  attack_ack, attack_hit
  );

  modport slave (
    input  attack_valid, attack_i, attack_j,
    output attack_ack, attack_hit
  );

endinterface

// File: rtl/shot_history.sv
// One bit per grid cell recording which cells the enemy has already shot.
module shot_history import battleship_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic set_en,
  input  idx_t set_idx,
  input  idx_t lookup_idx,
  output logic lookup_shot,
  output logic full
);

  logic [NCELLS-1:0] history;

  // NOTE: this is a small flop array, not a RAM, so resetting and bulk-clearing it is legal.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        history <= '0;
    else if (clear)  history <= '0;
    else if (set_en) history[set_idx] <= 1'b1;
  end

  assign lookup_shot = history[lookup_idx];
  assign full        = &history;

endmodule

// File: rtl/enemy_attack_controller.sv
// Enemy turn sequencer: random sampling with reject/retry, linear-scan fallback, one shot per turn.
// Optional macro HUNT_EN: after a hit, the next turn first probes the hit cell's neighbours.
module enemy_attack_controller import battleship_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       turn_start,
  input  coord_t     rand_i,
  input  coord_t     rand_j,
  enemy_attack_controller_if.master atk,
  output logic       turn_done,
  output logic       last_hit,
  output logic       board_full,
  output logic [4:0] shots_fired
);

  atk_state_e state, state_next;
  coord_t     cand_i, cand_j, scan_i, scan_j, lk_i, lk_j;
  logic [3:0] retry;
  logic       lk_shot, cand_ok, set_en;

`ifdef HUNT_EN
  logic       hunt_valid, nb_on_grid;
  logic [1:0] hunt_dir;
  coord_t     hunt_i, hunt_j, nb_i, nb_j;

  // Neighbour order: up, down, left, right.
  always_comb begin
    nb_i = hunt_i;
    nb_j = hunt_j;
    nb_on_grid = 1'b0;
    unique case (hunt_dir)
      2'd0:    begin nb_i = hunt_i - 3'd1; nb_on_grid = (hunt_i != 3'd0);      end
      2'd1:    begin nb_i = hunt_i + 3'd1; nb_on_grid = (hunt_i != GRID_LAST); end
      2'd2:    begin nb_j = hunt_j - 3'd1; nb_on_grid = (hunt_j != 3'd0);      end
      default: begin nb_j = hunt_j + 3'd1; nb_on_grid = (hunt_j != GRID_LAST); end
    endcase
  end
`endif

  assign cand_ok = (cand_i <= GRID_LAST) && (cand_j <= GRID_LAST);
  // A new_game in the same cycle as the ack wins: the shot is never recorded.
  assign set_en  = (state == FIRE) && atk.attack_ack && !new_game;

  shot_history u_history (
    .clk         (clk),
    .rst         (rst),
    .clear       (new_game),
    .set_en      (set_en),
    .set_idx     (cell_idx(atk.attack_i, atk.attack_j)),
    .lookup_idx  (cell_idx(lk_i, lk_j)),
    .lookup_shot (lk_shot),
    .full        (board_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    lk_i       = '0;
    lk_j       = '0;
    unique case (state)
      IDLE: if (turn_start) begin
        if (board_full) state_next = DONE;
`ifdef HUNT_EN
        else if (hunt_valid) state_next = HUNT;
`endif
        else state_next = SAMPLE;
      end
      SAMPLE: state_next = CHECK;
      CHECK: begin
        lk_i = cand_i;
        lk_j = cand_j;
        if (cand_ok && !lk_shot)   state_next = FIRE;
        else if (retry == RETRY_LAST) state_next = SCAN;
        else                       state_next = SAMPLE;
      end
      SCAN: begin
        lk_i = scan_i;
        lk_j = scan_j;
        if (!lk_shot) state_next = FIRE;
      end
      FIRE: if (atk.attack_ack) state_next = DONE;
      DONE: state_next = IDLE;
`ifdef HUNT_EN
      HUNT: begin
        lk_i = nb_i;
        lk_j = nb_j;
        if (nb_on_grid && !lk_shot) state_next = FIRE;
        else if (hunt_dir == 2'd3)  state_next = SAMPLE;
      end
`endif
      default: state_next = IDLE;
    endcase
    if (new_game) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand_i <= '0;  cand_j <= '0;
      scan_i <= '0;  scan_j <= '0;
      retry  <= '0;
      atk.attack_i <= '0;
      atk.attack_j <= '0;
      last_hit     <= 1'b0;
      shots_fired  <= '0;
`ifdef HUNT_EN
      hunt_valid <= 1'b0; hunt_dir <= '0; hunt_i <= '0; hunt_j <= '0;
`endif
    end else if (new_game) begin
      last_hit    <= 1'b0;
      shots_fired <= '0;
`ifdef HUNT_EN
      hunt_valid <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          retry <= '0;
`ifdef HUNT_EN
          hunt_dir <= '0;
`endif
        end
        SAMPLE: begin
          cand_i <= rand_i;
          cand_j <= rand_j;
        end
        CHECK: if (cand_ok && !lk_shot) begin
          atk.attack_i <= cand_i;
          atk.attack_j <= cand_j;
        end else begin
          retry  <= retry + 4'd1;
          scan_i <= '0;
          scan_j <= '0;
        end
        SCAN: if (!lk_shot) begin
          atk.attack_i <= scan_i;
          atk.attack_j <= scan_j;
        end else if (scan_j == GRID_LAST) begin
          scan_j <= '0;
          scan_i <= scan_i + 3'd1;
        end else begin
          scan_j <= scan_j + 3'd1;
        end
        FIRE: if (atk.attack_ack) begin
          last_hit <= atk.attack_hit;
          if (shots_fired != NCELLS_CNT) shots_fired <= shots_fired + 5'd1;
`ifdef HUNT_EN
          if (atk.attack_hit) begin
            hunt_valid <= 1'b1;
            hunt_i     <= atk.attack_i;
            hunt_j     <= atk.attack_j;
          end
`endif
        end
`ifdef HUNT_EN
        HUNT: if (nb_on_grid && !lk_shot) begin
          atk.attack_i <= nb_i;
          atk.attack_j <= nb_j;
        end else begin
          hunt_dir <= hunt_dir + 2'd1;
          if (hunt_dir == 2'd3) hunt_valid <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign atk.attack_valid = (state == FIRE);
  assign turn_done        = (state == DONE);

endmodule

// File: tb/tb_enemy_attack_controller.sv
// Scoreboard bench for enemy_attack_controller: a reference model predicts each shot when a turn starts.
module tb_enemy_attack_controller;
  import battleship_pkg::*;

  typedef struct {
    coord_t i;
    coord_t j;
  } shot_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       new_game, turn_start;
  coord_t     rand_i, rand_j;
  logic       turn_done, last_hit, board_full;
  logic [4:0] shots_fired;

  enemy_attack_controller_if atk_bus ();

  enemy_attack_controller dut (
    .clk         (clk),
    .rst         (rst),
    .new_game    (new_game),
    .turn_start  (turn_start),
    .rand_i      (rand_i),
    .rand_j      (rand_j),
    .atk         (atk_bus),
    .turn_done   (turn_done),
    .last_hit    (last_hit),
    .board_full  (board_full),
    .shots_fired (shots_fired)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  shot_t exp_q[$];
  shot_t cur_exp;
  bit    shot_m[NCELLS];
  int    shots_m;
  bit    last_hit_m;

  function automatic void model_clear();
    foreach (shot_m[k]) shot_m[k] = 1'b0;
    shots_m    = 0;
    last_hit_m = 1'b0;
  endfunction

  // First sample uses r1, every later sample uses r2; after MAX_RETRY rejects take the lowest free cell.
  function automatic shot_t model_pick(input coord_t r1i, r1j, r2i, r2j);
    shot_t s;
    int ci, cj;
    s.i = '0;
    s.j = '0;
    for (int k = 0; k < MAX_RETRY; k++) begin
      ci = (k == 0) ? int'(r1i) : int'(r2i);
      cj = (k == 0) ? int'(r1j) : int'(r2j);
      if (ci < GRID_N && cj < GRID_N && !shot_m[ci*GRID_N + cj]) begin
        s.i = coord_t'(ci);
        s.j = coord_t'(cj);
        return s;
      end
    end
    for (int idx = 0; idx < NCELLS; idx++) begin
      if (!shot_m[idx]) begin
        s.i = coord_t'(idx / GRID_N);
        s.j = coord_t'(idx % GRID_N);
        return s;
      end
    end
    return s;
  endfunction

  task automatic pulse_new_game();
    @(posedge clk); #1;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    model_clear();
  endtask

  task automatic drive_until_fire(input coord_t r1i, r1j, r2i, r2j, output bit ok);
    int n;
    @(posedge clk); #1;
    turn_start = 1'b1;
    rand_i = r1i;
    rand_j = r1j;
    @(posedge clk); #1;
    turn_start = 1'b0;
    @(posedge clk); #1;
    rand_i = r2i;
    rand_j = r2j;
    n = 0;
    while (atk_bus.attack_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (atk_bus.attack_valid === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fire_timeout: attack_valid=%b after %0d cycles, required 1", atk_bus.attack_valid, n);
    end
  endtask

  task automatic compare_pop(input string name);
    cur_exp = exp_q.pop_front();
    checks++;
    if (atk_bus.attack_i !== cur_exp.i || atk_bus.attack_j !== cur_exp.j) begin
      failures++;
      $display("FAIL %s_coord: got (%0d,%0d), required (%0d,%0d)", name,
               atk_bus.attack_i, atk_bus.attack_j, cur_exp.i, cur_exp.j);
    end
  endtask

  task automatic finish_turn(input bit hit);
    atk_bus.attack_ack = 1'b1;
    atk_bus.attack_hit = hit;
    @(posedge clk); #1;
    atk_bus.attack_ack = 1'b0;
    atk_bus.attack_hit = 1'b0;
    shot_m[int'(cur_exp.i)*GRID_N + int'(cur_exp.j)] = 1'b1;
    if (shots_m < NCELLS) shots_m++;
    last_hit_m = hit;
    checks++;
    if (turn_done !== 1'b1 || atk_bus.attack_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_response: turn_done=%b attack_valid=%b, required 1 0", turn_done, atk_bus.attack_valid);
    end
    checks++;
    if (last_hit !== last_hit_m || shots_fired !== 5'(shots_m)) begin
      failures++;
      $display("FAIL shot_result: last_hit=%b shots_fired=%0d, required %b %0d", last_hit, shots_fired, last_hit_m, shots_m);
    end
    @(posedge clk); #1;
    checks++;
    if (turn_done !== 1'b0) begin
      failures++;
      $display("FAIL turn_done_width: turn_done=%b one cycle later, required 0", turn_done);
    end
  endtask

  task automatic run_turn(input string name, input coord_t r1i, r1j, r2i, r2j, input bit hit);
    bit ok;
    exp_q.push_back(model_pick(r1i, r1j, r2i, r2j));
    drive_until_fire(r1i, r1j, r2i, r2j, ok);
    if (ok) begin
      compare_pop(name);
      finish_turn(hit);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (atk_bus.attack_valid !== 1'b0 || turn_done !== 1'b0 || last_hit !== 1'b0 ||
        shots_fired !== 5'd0 || board_full !== 1'b0 ||
        atk_bus.attack_i !== 3'd0 || atk_bus.attack_j !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b done=%b hit=%b shots=%0d full=%b ij=(%0d,%0d), required all 0",
               atk_bus.attack_valid, turn_done, last_hit, shots_fired, board_full,
               atk_bus.attack_i, atk_bus.attack_j);
    end
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_first_shot();
    pulse_new_game();
    exp_q.push_back(model_pick(3'd2, 3'd3, 3'd2, 3'd3));
    @(posedge clk); #1;
    turn_start = 1'b1;
    rand_i = 3'd2;
    rand_j = 3'd3;
    @(posedge clk); #1;
    turn_start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (atk_bus.attack_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: attack_valid=%b at +2 edges, required 0", atk_bus.attack_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (atk_bus.attack_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_fire: attack_valid=%b at +3 edges, required 1", atk_bus.attack_valid);
      void'(exp_q.pop_front());
    end else begin
      compare_pop("first_shot");
      finish_turn(1'b1);
    end
  endtask

  task automatic test_reject();
    pulse_new_game();
    run_turn("reject_setup", 3'd2, 3'd3, 3'd2, 3'd3, 1'b0);
    run_turn("reject", 3'd2, 3'd3, 3'd4, 3'd0, 1'b0);
    run_turn("out_of_range", 3'd7, 3'd1, 3'd1, 3'd5, 1'b0);
  endtask

  task automatic test_scan();
    pulse_new_game();
    for (int idx = 0; idx < 7; idx++)
      run_turn("scan_setup", coord_t'(idx / GRID_N), coord_t'(idx % GRID_N),
               coord_t'(idx / GRID_N), coord_t'(idx % GRID_N), 1'b0);
    run_turn("scan", 3'd0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  task automatic test_board_full();
    int guard;
    checks++;
    if (board_full !== 1'b0) begin
      failures++;
      $display("FAIL board_not_full: board_full=%b with %0d shots, required 0", board_full, shots_m);
    end
    guard = 0;
    while (shots_m < NCELLS && guard < 40) begin
      run_turn("fill", coord_t'($urandom_range(0, 7)), coord_t'($urandom_range(0, 7)),
               coord_t'($urandom_range(0, 7)), coord_t'($urandom_range(0, 7)), 1'b0);
      guard++;
    end
    checks++;
    if (board_full !== 1'b1 || shots_fired !== 5'd25) begin
      failures++;
      $display("FAIL board_full: board_full=%b shots_fired=%0d, required 1 25", board_full, shots_fired);
    end
    @(posedge clk); #1;
    turn_start = 1'b1;
    @(posedge clk); #1;
    turn_start = 1'b0;
    checks++;
    if (turn_done !== 1'b1 || atk_bus.attack_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_turn: turn_done=%b attack_valid=%b, required 1 0", turn_done, atk_bus.attack_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (turn_done !== 1'b0 || atk_bus.attack_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_turn_end: turn_done=%b attack_valid=%b, required 0 0", turn_done, atk_bus.attack_valid);
    end
  endtask

  task automatic test_new_game();
    bit ok;
    pulse_new_game();
    run_turn("ng_setup", 3'd1, 3'd1, 3'd1, 3'd1, 1'b1);
    drive_until_fire(3'd3, 3'd3, 3'd3, 3'd3, ok);
    new_game = 1'b1;
    atk_bus.attack_ack = 1'b1;
    atk_bus.attack_hit = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    atk_bus.attack_ack = 1'b0;
    atk_bus.attack_hit = 1'b0;
    model_clear();
    checks++;
    if (atk_bus.attack_valid !== 1'b0 || turn_done !== 1'b0 || shots_fired !== 5'd0 ||
        last_hit !== 1'b0 || board_full !== 1'b0) begin
      failures++;
      $display("FAIL new_game_clear: valid=%b done=%b shots=%0d hit=%b full=%b, required all 0",
               atk_bus.attack_valid, turn_done, shots_fired, last_hit, board_full);
    end
    @(posedge clk); #1;
    checks++;
    if (turn_done !== 1'b0) begin
      failures++;
      $display("FAIL new_game_no_done: turn_done=%b, required 0", turn_done);
    end
    run_turn("after_new_game", 3'd1, 3'd1, 3'd1, 3'd1, 1'b0);
  endtask

  task automatic test_ack_ignored();
    @(posedge clk); #1;
    atk_bus.attack_ack = 1'b1;
    atk_bus.attack_hit = 1'b1;
    @(posedge clk); #1;
    atk_bus.attack_ack = 1'b0;
    atk_bus.attack_hit = 1'b0;
    checks++;
    if (shots_fired !== 5'(shots_m) || last_hit !== last_hit_m || turn_done !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: shots=%0d hit=%b done=%b, required %0d %b 0",
               shots_fired, last_hit, turn_done, shots_m, last_hit_m);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    drive_until_fire(3'd2, 3'd2, 3'd2, 3'd2, ok);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (atk_bus.attack_valid !== 1'b0 || shots_fired !== 5'd0 || turn_done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b shots=%0d done=%b, required 0 0 0",
               atk_bus.attack_valid, shots_fired, turn_done);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (atk_bus.attack_valid !== 1'b0 || turn_done !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: valid=%b done=%b, required 0 0", atk_bus.attack_valid, turn_done);
    end
    run_turn("post_reset", 3'd2, 3'd2, 3'd2, 3'd2, 1'b0);
  endtask

`ifdef HUNT_EN
  task automatic test_hunt();
    bit ok;
    pulse_new_game();
    run_turn("hunt_setup", 3'd0, 3'd0, 3'd0, 3'd0, 1'b1);
    drive_until_fire(3'd4, 3'd4, 3'd4, 3'd4, ok);
    if (ok) begin
      checks++;
      if (atk_bus.attack_i !== 3'd1 || atk_bus.attack_j !== 3'd0) begin
        failures++;
        $display("FAIL hunt_coord: got (%0d,%0d), required (1,0)", atk_bus.attack_i, atk_bus.attack_j);
      end
      cur_exp.i = 3'd1;
      cur_exp.j = 3'd0;
      finish_turn(1'b0);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    new_game = 1'b0;
    turn_start = 1'b0;
    rand_i = '0;
    rand_j = '0;
    atk_bus.attack_ack = 1'b0;
    atk_bus.attack_hit = 1'b0;
    model_clear();

    test_reset();
    test_first_shot();
    test_reject();
    test_scan();
    test_board_full();
    test_new_game();
    test_ack_ignored();
    test_async_reset();
`ifdef HUNT_EN
    test_hunt();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
